// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO unit: funct codes, FSM state encoding
// and default sizes.
package hilo_unit_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int MUL_CYCLES_DEF = 32;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/hilo_regfile.sv
// Architectural HI/LO registers with independent write enables and a
// single read port selecting HI or LO.
module hilo_regfile
  import hilo_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_hi_we,
  input  logic              i_lo_we,
  input  logic [DATA_W-1:0] i_hi_d,
  input  logic [DATA_W-1:0] i_lo_d,
  input  logic              i_rd_lo,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  // HI/LO storage; reset clears both
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_hi_we) r_hi <= i_hi_d;
      if (i_lo_we) r_lo <= i_lo_d;
    end
  end

  assign o_rd_data = i_rd_lo ? r_lo : r_hi;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO unit: sequences one unsigned multiply on the external shift-add
// multiplier, captures the product into HI/LO, and serves MFHI/MFLO/
// MTHI/MTLO requests on a valid/ready port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request; moves/reads complete in one edge
// START    | mul_start pulse, counter cleared
// WAIT     | counting out the multiplier iterations
// CAPTURE  | product stable; HI/LO loaded at the end of this cycle
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [5:0]          i_signal,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [DATA_W-1:0]   i_data_in,
  input  logic [2*DATA_W-1:0] i_prod_in,
  output logic                o_mul_start,
  output logic                o_busy,
  output logic [DATA_W-1:0]   o_data_out,
  output logic                o_out_valid
);

  localparam int              CNT_W    = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  state_e            r_state;
  state_e            w_next_state;
  logic [CNT_W-1:0]  r_count;
  logic              w_accept;
  logic              w_capture;
  logic              w_is_mf;
  logic              w_hi_we;
  logic              w_lo_we;
  logic [DATA_W-1:0] w_hi_d;
  logic [DATA_W-1:0] w_lo_d;
  logic [DATA_W-1:0] w_rd_data;

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_mul_start = (r_state == ST_START);

  assign w_accept  = i_req_valid && o_req_ready;
  assign w_capture = (r_state == ST_CAPTURE);
  assign w_is_mf   = w_accept && ((i_signal == FN_MFHI) || (i_signal == FN_MFLO));

  // Capture owns both registers; moves only happen from IDLE so they never collide
  assign w_hi_we = w_capture || (w_accept && (i_signal == FN_MTHI));
  assign w_lo_we = w_capture || (w_accept && (i_signal == FN_MTLO));
  assign w_hi_d  = w_capture ? i_prod_in[2*DATA_W-1:DATA_W] : i_data_in;
  assign w_lo_d  = w_capture ? i_prod_in[DATA_W-1:0]        : i_data_in;

  hilo_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_hi_we   (w_hi_we),
    .i_lo_we   (w_lo_we),
    .i_hi_d    (w_hi_d),
    .i_lo_d    (w_lo_d),
    .i_rd_lo   (i_signal == FN_MFLO),
    .o_rd_data (w_rd_data)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept && (i_signal == FN_MULTU)) w_next_state = ST_START;
      ST_START:   w_next_state = ST_WAIT;
      ST_WAIT:    if (r_count == CNT_LAST) w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Iteration counter: cleared in START, counts up through WAIT
  always_ff @(posedge i_clk) begin
    if (i_reset)                  r_count <= '0;
    else if (r_state == ST_START) r_count <= '0;
    else if (r_state == ST_WAIT)  r_count <= r_count + CNT_W'(1);
  end

  // Read result register and its one-cycle valid pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data_out  <= '0;
      o_out_valid <= 1'b0;
    end else begin
      o_out_valid <= w_is_mf;
      if (w_is_mf) o_data_out <= w_rd_data;
    end
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Downstream consumer of the 64-bit shift-add multiplier.
- Sequences one unsigned multiply and waits out the multiplier's fixed iteration count. Then captures the product into the architectural HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO on a valid/ready request port.
- Sits between the ALU-control funct decode and the register-file writeback mux.

Parameters:
- MUL_CYCLES, 32, clock cycles the multiplier needs from mulStart to a stable product (counter width = clog2(MUL_CYCLES+1)).
- DATA_W, 32, width of HI, LO and dataOut; product width is 2*DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Signal  in  6  funct code of the request.
- reqValid  in  1  request present on Signal/dataIn.
- reqReady  out  1  unit can accept a request this cycle.
- dataIn  in  DATA_W  operand for MTHI/MTLO.
- prodIn  in  2*DATA_W  product from the multiplier.
- mulStart  out  1  one-cycle pulse; multiplier latches operands and clears its accumulator.
- busy  out  1  multiply in flight.
- dataOut  out  DATA_W  MFHI/MFLO result.
- outValid  out  1  one-cycle pulse qualifying dataOut.

Behaviour:
- Reset (sync, active-high) takes priority over everything. HI=0, LO=0, dataOut=0, outValid=0, mulStart=0, busy=0, counter=0, state=IDLE.
- Funct constants: MULTU=6'b011001, MFHI=6'b010000, MTHI=6'b010001, MFLO=6'b010010, MTLO=6'b010011. All other codes are accepted and ignored, with no state change and no outValid.
- A request is accepted on a rising edge where reqValid && reqReady.
- reqReady = (state==IDLE). Combinational from state only; no dependence on reqValid.
- States:
  - IDLE: accept a request. MULTU -> START.
  - START: mulStart=1 for this cycle, busy=1, counter<=0 -> WAIT.
  - WAIT: busy=1, counter increments each cycle. When counter==MUL_CYCLES-1 -> CAPTURE.
  - CAPTURE: busy=1. At the end of the cycle, HI<=prodIn[63:32] and LO<=prodIn[31:0] -> IDLE.
- MULTU timing: accepted at edge T. HI/LO show the new product after edge T+MUL_CYCLES+2. busy is high for exactly MUL_CYCLES+2 cycles. reqReady is low for that same window.
- MFHI/MFLO:
  - Accepted at edge T: dataOut<=HI (or LO) at edge T, and outValid=1 for the cycle after T only.
  - dataOut holds its value until the next MFHI/MFLO.
  - outValid returns to 0 otherwise.
- MTHI/MTLO: HI (or LO) <= dataIn at the accepting edge. Readable by an MFHI/MFLO accepted at the very next edge.
- Back-to-back: a new request can be accepted every cycle in IDLE. The first request after a multiply can be accepted on the edge that leaves CAPTURE+1, i.e. the first cycle with reqReady=1.
- Stall rule: while busy, reqValid is held by the requester. Nothing is dropped or queued; the request is simply not accepted.
- Reset mid-multiply: abort to IDLE, zero HI/LO, no capture. mulStart does not pulse again until a new MULTU.
- prodIn is sampled only in CAPTURE; its value in every other state is ignored.
- Width: no sign handling (unsigned). HI/LO are a direct split of the 64-bit product; there is no overflow condition.

Decomposition:
- Shared package: funct constants (MULTU, MFHI, MTHI, MFLO, MTLO), state encoding (IDLE, START, WAIT, CAPTURE), DATA_W default.
- The multiplier itself stays separate.
- One natural sub-module: hilo_regfile, holding the HI/LO registers with write-enable and a read mux. The FSM and counter stay in hilo_unit.

Test Plan:
- Reset then MFHI, MFLO -> dataOut=0 on both with outValid pulses; reqReady=1 throughout.
- MTHI 0xDEADBEEF, then MFHI next edge -> dataOut=0xDEADBEEF one cycle later. MFLO still returns 0.
- MULTU with prodIn model = 0x00000001_80000000 after MUL_CYCLES -> mulStart 1-cycle pulse, busy high for 34 cycles. Then MFHI=0x00000001 and MFLO=0x80000000.
- MFLO held with reqValid during busy -> not accepted until reqReady rises, then returns the new LO. Exactly one outValid.
- Reset asserted in WAIT, 10 cycles after MULTU -> IDLE next edge, HI=LO=0, busy=0, no later capture.
- Signal=6'b100000 with reqValid -> accepted, HI/LO unchanged, outValid stays 0.
